// File: rtl/irq_ctrl.sv
// irq_ctrl - eight-line interrupt request controller.
//
// This block captures rising edges on the request lines into a pending
// register, gates them with a software mask, and presents the
// highest-priority enabled request (bit N-1 highest) on a valid/ack handshake.
// An accepted acknowledge clears the pending bit that was being serviced.
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   asynchronous active-high reset
//   req         in   [N-1:0] level request lines; a 0->1 transition raises an interrupt
//   mask_we     in   mask register write strobe
//   mask_wdata  in   [N-1:0] new mask (1 = line enabled)
//   irq_ack     in   consumer acknowledge, sampled only while irq_valid=1
//   ovr_clr     in   clears the overrun register
//   irq_valid   out  an interrupt id is being presented
//   irq_id      out  [IDW-1:0] presented interrupt index, stable while irq_valid=1
//   pending     out  [N-1:0] pending register (unmasked)
//   mask        out  [N-1:0] mask register
//   overrun     out  [N-1:0] sticky flag: edge arrived while line already pending
module irq_ctrl #(
  parameter int N   = 8,
  parameter int IDW = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic           mask_we,
  input  logic [N-1:0]   mask_wdata,
  input  logic           irq_ack,
  input  logic           ovr_clr,
  output logic           irq_valid,
  output logic [IDW-1:0] irq_id,
  output logic [N-1:0]   pending,
  output logic [N-1:0]   mask,
  output logic [N-1:0]   overrun
);

  typedef enum logic {
    IDLE,
    PRESENT
  } state_t;

  state_t         state;
  logic [N-1:0]   req_q;
  logic [N-1:0]   edge_vec;
  logic [N-1:0]   clr_vec;
  logic [N-1:0]   new_ovr;
  logic [N-1:0]   sel;
  logic [IDW-1:0] sel_id;

  always_comb begin
    edge_vec = req & ~req_q;
    sel      = pending & mask;
  end

  // The presented line is cleared only on an acknowledge accepted while
  // presenting. An acknowledge in IDLE does nothing.
  always_comb begin
    clr_vec = '0;
    if (state == PRESENT && irq_ack) begin
      clr_vec[irq_id] = 1'b1;
    end
  end

  // A line being cleared in this cycle is consumed, so a simultaneous new
  // edge on it is a fresh interrupt and not an overrun.
  always_comb begin
    new_ovr = edge_vec & pending & ~clr_vec;
  end

  // Priority encoder: ascending scan, so the highest set bit is written last
  // and wins.
  always_comb begin
    sel_id = '0;
    for (int i = 0; i < N; i++) begin
      if (sel[i]) begin
        sel_id = IDW'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      req_q     <= '0;
      pending   <= '0;
      overrun   <= '0;
      mask      <= '1;
      irq_valid <= 1'b0;
      irq_id    <= '0;
    end else begin
      req_q <= req;
      // Set wins over clear. Masked lines still capture edges.
      pending <= (pending & ~clr_vec) | edge_vec;

      // A new overrun event takes precedence over the clear.
      if (ovr_clr) begin
        overrun <= new_ovr;
      end else begin
        overrun <= overrun | new_ovr;
      end

      if (mask_we) begin
        mask <= mask_wdata;
      end

      case (state)
        IDLE: begin
          if (sel != '0) begin
            irq_id    <= sel_id;
            irq_valid <= 1'b1;
            state     <= PRESENT;
          end
        end
        PRESENT: begin
          // Once presented, the id is committed until it is acknowledged.
          if (irq_ack) begin
            irq_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          irq_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl - self-checking bench for irq_ctrl.
// It runs a table of directed vectors that follow the test plan scenarios,
// then a hand-written asynchronous-reset sequence, then randomized stimulus
// checked against a behavioural model.
module tb_irq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       mask_we;
  logic [7:0] mask_wdata;
  logic       irq_ack;
  logic       ovr_clr;
  logic       irq_valid;
  logic [2:0] irq_id;
  logic [7:0] pending;
  logic [7:0] mask;
  logic [7:0] overrun;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  irq_ctrl #(.N(8), .IDW(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .irq_ack    (irq_ack),
    .ovr_clr    (ovr_clr),
    .irq_valid  (irq_valid),
    .irq_id     (irq_id),
    .pending    (pending),
    .mask       (mask),
    .overrun    (overrun)
  );

  // Behavioural model state: a set of pending lines, the mask, the overrun
  // flags, and the presentation currently outstanding, if there is one.
  logic [7:0] m_pend, m_mask, m_ovr, m_prev_req;
  logic       m_busy;
  int         m_id;

  function automatic int highest(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_pend = 8'h00; m_mask = 8'hFF; m_ovr = 8'h00;
    m_prev_req = 8'h00; m_busy = 1'b0; m_id = 0;
  endtask

  // Apply one clock edge to the model, using the inputs that are currently driven.
  task automatic model_step();
    logic [7:0] rose, served, again, enabled;
    rose    = req & ~m_prev_req;
    served  = (m_busy && irq_ack) ? (8'h01 << m_id) : 8'h00;
    again   = rose & m_pend & ~served;
    enabled = m_pend & m_mask;
    if (m_busy) begin
      if (irq_ack) m_busy = 1'b0;
    end else if (enabled != 8'h00) begin
      m_busy = 1'b1;
      m_id   = highest(enabled);
    end
    m_ovr      = ovr_clr ? again : (m_ovr | again);
    m_pend     = (m_pend & ~served) | rose;
    if (mask_we) m_mask = mask_wdata;
    m_prev_req = req;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  // Advance one clock edge, then sample the outputs 1 ns later.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input logic [7:0] r, input logic we, input logic [7:0] wd,
                       input logic a, input logic oc);
    req = r; mask_we = we; mask_wdata = wd; irq_ack = a; ovr_clr = oc;
  endtask

  typedef struct {
    logic [7:0] req;
    logic       we;
    logic [7:0] wd;
    logic       ack;
    logic       oc;
    logic       e_valid;
    logic [2:0] e_id;
    logic [7:0] e_pend;
    logic [7:0] e_mask;
    logic [7:0] e_ovr;
  } vec_t;

  vec_t vt[$];

  initial begin
    // Columns: req, we, wd, ack, ovr_clr | valid, id, pending, mask, overrun (after the edge).
    // Single pulse on req[5].
    vt.push_back('{8'h20,0,8'h00,0,0, 0,3'd0,8'h20,8'hFF,8'h00});
    vt.push_back('{8'h00,0,8'h00,0,0, 1,3'd5,8'h20,8'hFF,8'h00});
    vt.push_back('{8'h00,0,8'h00,1,0, 0,3'd5,8'h00,8'hFF,8'h00});
    // Three lines together, served in priority order 6, 3, 1.
    vt.push_back('{8'h4A,0,8'h00,0,0, 0,3'd5,8'h4A,8'hFF,8'h00});
    vt.push_back('{8'h00,0,8'h00,0,0, 1,3'd6,8'h4A,8'hFF,8'h00});
    vt.push_back('{8'h00,0,8'h00,1,0, 0,3'd6,8'h0A,8'hFF,8'h00});
    vt.push_back('{8'h00,0,8'h00,0,0, 1,3'd3,8'h0A,8'hFF,8'h00});
    vt.push_back('{8'h00,0,8'h00,1,0, 0,3'd3,8'h02,8'hFF,8'h00});
    vt.push_back('{8'h00,0,8'h00,0,0, 1,3'd1,8'h02,8'hFF,8'h00});
    vt.push_back('{8'h00,0,8'h00,1,0, 0,3'd1,8'h00,8'hFF,8'h00});
    // Masking with 0F: line 7 stays pending until the mask is reopened.
    vt.push_back('{8'h00,1,8'h0F,0,0, 0,3'd1,8'h00,8'h0F,8'h00});
    vt.push_back('{8'h84,0,8'h00,0,0, 0,3'd1,8'h84,8'h0F,8'h00});
    vt.push_back('{8'h00,0,8'h00,0,0, 1,3'd2,8'h84,8'h0F,8'h00});
    vt.push_back('{8'h00,0,8'h00,1,0, 0,3'd2,8'h80,8'h0F,8'h00});
    vt.push_back('{8'h00,0,8'h00,0,0, 0,3'd2,8'h80,8'h0F,8'h00});
    vt.push_back('{8'h00,1,8'hFF,0,0, 0,3'd2,8'h80,8'hFF,8'h00});
    vt.push_back('{8'h00,0,8'h00,0,0, 1,3'd7,8'h80,8'hFF,8'h00});
    vt.push_back('{8'h00,0,8'h00,1,0, 0,3'd7,8'h00,8'hFF,8'h00});
    // Overrun on line 4 while it is presented, then ack, then ovr_clr.
    vt.push_back('{8'h10,0,8'h00,0,0, 0,3'd7,8'h10,8'hFF,8'h00});
    vt.push_back('{8'h00,0,8'h00,0,0, 1,3'd4,8'h10,8'hFF,8'h00});
    vt.push_back('{8'h10,0,8'h00,0,0, 1,3'd4,8'h10,8'hFF,8'h10});
    vt.push_back('{8'h00,0,8'h00,1,0, 0,3'd4,8'h00,8'hFF,8'h10});
    vt.push_back('{8'h00,0,8'h00,0,1, 0,3'd4,8'h00,8'hFF,8'h00});
    // Ack of id 0 in the same cycle as a new edge on req[0].
    vt.push_back('{8'h01,0,8'h00,0,0, 0,3'd4,8'h01,8'hFF,8'h00});
    vt.push_back('{8'h00,0,8'h00,0,0, 1,3'd0,8'h01,8'hFF,8'h00});
    vt.push_back('{8'h01,0,8'h00,1,0, 0,3'd0,8'h01,8'hFF,8'h00});
    vt.push_back('{8'h00,0,8'h00,0,0, 1,3'd0,8'h01,8'hFF,8'h00});
    vt.push_back('{8'h00,0,8'h00,1,0, 0,3'd0,8'h00,8'hFF,8'h00});
  end

  task automatic check_reset_values(input string tag);
    chk({tag, "_valid"},   {7'd0, irq_valid}, 8'h00);
    chk({tag, "_id"},      {5'd0, irq_id},    8'h00);
    chk({tag, "_pending"}, pending,           8'h00);
    chk({tag, "_mask"},    mask,              8'hFF);
    chk({tag, "_overrun"}, overrun,           8'h00);
  endtask

  initial begin
    rst = 1'b1;
    drive(8'h00, 0, 8'h00, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b0;

    // Directed table.
    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].req, vt[i].we, vt[i].wd, vt[i].ack, vt[i].oc);
      cycle();
      chk($sformatf("vec%0d_valid", i),   {7'd0, irq_valid}, {7'd0, vt[i].e_valid});
      chk($sformatf("vec%0d_id", i),      {5'd0, irq_id},    {5'd0, vt[i].e_id});
      chk($sformatf("vec%0d_pending", i), pending,           vt[i].e_pend);
      chk($sformatf("vec%0d_mask", i),    mask,              vt[i].e_mask);
      chk($sformatf("vec%0d_overrun", i), overrun,           vt[i].e_ovr);
      $display("vec %0d req=%02h ack=%0d -> valid=%0d id=%0d pend=%02h mask=%02h ovr=%02h",
               i, vt[i].req, vt[i].ack, irq_valid, irq_id, pending, mask, overrun);
    end

    // Asynchronous reset while C0 is pending and id 7 is presented.
    drive(8'hC0, 0, 8'h00, 0, 0);
    cycle();
    drive(8'h00, 0, 8'h00, 0, 0);
    cycle();
    chk("pre_rst_valid",   {7'd0, irq_valid}, 8'h01);
    chk("pre_rst_pending", pending,           8'hC0);
    #2;
    rst = 1'b1;
    req = 8'h01;
    #1;
    check_reset_values("async_rst");
    $display("async reset: valid=%0d id=%0d pend=%02h mask=%02h ovr=%02h",
             irq_valid, irq_id, pending, mask, overrun);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    cycle();
    chk("rel1_pending", pending,           8'h01);
    chk("rel1_valid",   {7'd0, irq_valid}, 8'h00);
    cycle();
    chk("rel2_valid",   {7'd0, irq_valid}, 8'h01);
    chk("rel2_id",      {5'd0, irq_id},    8'h00);
    $display("release: valid=%0d id=%0d pend=%02h", irq_valid, irq_id, pending);

    // Randomized stimulus checked against the model.
    for (int n = 0; n < 600; n++) begin
      logic [7:0] r;
      r = 8'($urandom);
      if ($urandom_range(0, 3) != 0) r = req ^ (8'h01 << $urandom_range(0, 7));
      drive(r, ($urandom_range(0, 15) == 0), 8'($urandom),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0));
      cycle();
      chk($sformatf("rnd%0d_valid", n),   {7'd0, irq_valid}, {7'd0, m_busy});
      if (m_busy)
        chk($sformatf("rnd%0d_id", n),    {5'd0, irq_id},    8'(m_id));
      chk($sformatf("rnd%0d_pending", n), pending,           m_pend);
      chk($sformatf("rnd%0d_mask", n),    mask,              m_mask);
      chk($sformatf("rnd%0d_overrun", n), overrun,           m_ovr);
      $display("rnd %0d req=%02h ack=%0d -> valid=%0d id=%0d pend=%02h ovr=%02h",
               n, req, irq_ack, irq_valid, irq_id, pending, overrun);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
